// File: rtl/data_memory_sweep.sv
// data_memory_sweep: parametrised single-port synchronous data memory.
// Registered reads with a valid strobe, write-first read-during-write,
// address bounds check, and a clear engine that zeroes one word per cycle
// after reset or on request (busy while sweeping, all accesses ignored).
// Optional feature macro: DMEM_PARITY_EN -- each word carries an even parity
// bit and perr flags a parity failure on the returned word.
module data_memory_sweep #(
   parameter int DATA_W = 9,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              busy,
   output logic              perr
);

`ifdef DMEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   // One extra bit so DEPTH == 2^ADDR_W is representable for the bounds check
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONE_C   = ADDR_W'(1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

`ifdef DMEM_PARITY_EN
   // Even parity bit over a data word
   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   // Stored word (data plus parity) fails its even-parity check
   function automatic logic parity_fail(input logic [MEM_W-1:0] w);
      return ^w;
   endfunction
`endif

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [MEM_W-1:0]  mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic              rvalid_q;
   logic              perr_q;
   logic              perr_d;

   logic              in_range_s;
   logic              acc_en_s;
   logic              wr_en_s;
   logic              rd_en_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [MEM_W-1:0]  mem_wword_s;
   logic [MEM_W-1:0]  wr_word_s;
   logic [MEM_W-1:0]  rd_word_s;

   // Decode accepted accesses and steer the single write port between sweep and user
   always_comb begin
      in_range_s = ({1'b0, addr} < DEPTH_C);
      // a clr request claims the cycle, so a same-cycle access is dropped
      acc_en_s   = (state_q == ST_IDLE) && !clr;
      wr_en_s    = acc_en_s && we && in_range_s;
      rd_en_s    = acc_en_s && re;
`ifdef DMEM_PARITY_EN
      wr_word_s  = {even_parity(wdata), wdata};
`else
      wr_word_s  = wdata;
`endif
      if (state_q == ST_CLEAR) begin
         // sweep writes zero data with zero parity, which is a valid even-parity word
         mem_we_s    = 1'b1;
         mem_addr_s  = cnt_q;
         mem_wword_s = {MEM_W{1'b0}};
      end else begin
         mem_we_s    = wr_en_s;
         mem_addr_s  = addr;
         mem_wword_s = wr_word_s;
      end
   end

   // Next read data: write-first bypass, zero for out-of-range, hold when idle
   always_comb begin
      rd_word_s = {MEM_W{1'b0}};
      rdata_d   = rdata_q;
      perr_d    = 1'b0;
      if (rd_en_s) begin
         if (in_range_s) begin
            if (wr_en_s) begin
               rd_word_s = wr_word_s;
            end else begin
               rd_word_s = mem_q[addr];
            end
            rdata_d = rd_word_s[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
            perr_d  = parity_fail(rd_word_s);
`else
            perr_d  = 1'b0;
`endif
         end else begin
            rdata_d = {DATA_W{1'b0}};
            perr_d  = 1'b0;
         end
      end else begin
         rdata_d = rdata_q;
         perr_d  = 1'b0;
      end
   end

   // Sweep/idle sequencing plus registered read outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_CLEAR;
         cnt_q    <= {ADDR_W{1'b0}};
         rdata_q  <= {DATA_W{1'b0}};
         rvalid_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         rvalid_q <= rd_en_s;
         rdata_q  <= rdata_d;
         perr_q   <= perr_d;
         case (state_q)
            ST_CLEAR: begin
               // clr is ignored here: the running sweep is never restarted
               if (cnt_q == LAST_C) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= {ADDR_W{1'b0}};
               end else begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= cnt_q + ONE_C;
               end
            end
            ST_IDLE: begin
               if (clr) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= {ADDR_W{1'b0}};
               end else begin
                  state_q <= ST_IDLE;
                  cnt_q   <= cnt_q;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
               cnt_q   <= {ADDR_W{1'b0}};
            end
         endcase
      end
   end

   // Array write port; contents are cleared only by the sweep, never by reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_addr_s] <= mem_wword_s;
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign busy   = (state_q == ST_CLEAR);
   assign perr   = perr_q;

endmodule

// File: doc/data_memory_sweep.md
# data_memory_sweep

Parametrised single-port synchronous data memory for the lab datapath. It replaces the fixed 9-bit × 256 store. Over the old store it adds:
- registered reads with a valid strobe;
- defined read-during-write behaviour;
- an address bounds check;
- a sequenced clear engine that zeroes the array one word per cycle after reset or on request.

It sits between the ALU/register-file stage and write-back, and is driven by the control unit.

## Interface
- DATA_W, 9, data word width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 256, number of words; must satisfy DEPTH ≤ 2^ADDR_W
- clk  in  1  rising-edge clock; only clock in the block
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear request, sampled only while idle
- we  in  1  write enable
- re  in  1  read enable
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  registered read data
- rvalid  out  1  one-cycle strobe: rdata is valid
- busy  out  1  clear engine active; all accesses ignored
- perr  out  1  parity error on current rdata (only with DMEM_PARITY_EN; otherwise tied 0)

## Operation
- **FSM states**
  - CLEAR: writes 0 to mem[cnt], then cnt+1; busy=1.
  - IDLE: normal accesses; busy=0.
- **Transitions**
  - rst_n low → CLEAR, with cnt=0.
  - CLEAR with cnt==DEPTH-1 → IDLE after that word is written.
  - IDLE with clr=1 → CLEAR, with cnt=0. Any we/re in the same cycle is ignored.
- **CLEAR behaviour**
  - clr is ignored; the sweep is not restarted.
  - we/re are ignored: no write, and rvalid stays 0.
- **Write:** in IDLE with we=1 and addr<DEPTH, mem[addr] ← wdata at the clock edge.
- **Read:** in IDLE with re=1, the next cycle gives rdata=mem[addr] and rvalid=1.
- **Same-cycle read and write:** with we=1 and re=1 the behaviour is write-first; rdata returns the new wdata.
- **Out-of-range address (addr ≥ DEPTH)**
  - Writes are dropped.
  - Reads return rdata=0 with rvalid=1.
- **rdata hold:** rdata keeps its last value when rvalid=0. It is not zeroed except by reset.
- **Array reset:** the array is never asynchronously reset. Only the sweep clears it.

## Timing
- **Reset values:** rdata=0, rvalid=0, busy=1, perr=0, cnt=0, state=CLEAR.
- **Post-reset sweep:** the sweep starts on the first rising edge after rst_n deasserts. It takes exactly DEPTH cycles.
  - busy falls in the cycle after the edge that writes word DEPTH-1.
  - The first accepted access is the first edge at which busy=0.
- **clr sweep:** from clr sampled high, busy=1 on the next cycle and stays high for DEPTH cycles.
- **Read latency:** 1 cycle. Back-to-back reads are allowed every cycle, giving one rvalid pulse per request.
- **Write latency:** 0 cycles. The data is visible to a read issued on the next edge.
- **Reset mid-sweep or mid-read:** async reset immediately forces the reset values. The sweep then restarts from word 0 after release.
- **Array contents after a mid-sweep reset:** unspecified until the new sweep completes.

## Configuration
- **DMEM_PARITY_EN defined**
  - Each word stores DATA_W+1 bits: data plus even parity over the data.
  - Writes generate the parity bit. The sweep writes 0 with parity 0.
  - On every rvalid, perr = the parity check fails on the stored word.
  - perr is registered alongside rdata, is 0 whenever rvalid=0, and is forced 0 for out-of-range reads.
- **DMEM_PARITY_EN undefined**
  - Storage is DATA_W bits and perr is constant 0.
  - There is no other behavioural difference.

## Test plan
- **Reset sweep:** preload the array with 0x1FF by backdoor, then pulse rst_n low. busy must stay high for exactly 256 cycles. Afterwards, reads of addr 0, 127 and 255 each return 0 with rvalid one cycle after re.
- **Write/read:** write 0x0A5 @3 and 0x15A @200, then read both. rdata must be 0x0A5 then 0x15A on consecutive cycles, with rvalid high for 2 cycles.
- **Read-during-write:** with mem[7]=0x011, drive we=re=1, addr=7, wdata=0x0F0. The next cycle must give rdata=0x0F0.
- **Clear request mid-traffic:** write 0x1FF @10, then assert clr together with we to @11. busy must rise and stay high for 256 cycles, the @11 write must be dropped, and mem[10] must read 0 afterwards.
- **Out of range:** with DEPTH=200, write @250, then read @250. The read must return 0 with rvalid=1, and no in-range word may change.
- **Async reset mid-read, with DMEM_PARITY_EN:**
  - Drop rst_n during a read: rvalid must clear immediately and busy must go high.
  - After the sweep, flip a stored parity bit by backdoor on @5 and read @5. perr must equal 1 with rvalid.
